// File: rtl/dcache_pkg.sv
// Shared types, derived widths and address field helpers for the data cache.
package dcache_pkg;

  localparam int DC_ADDR_WIDTH = 32;
  localparam int DC_DATA_WIDTH = 32;
  localparam int DC_INDEX_BITS = 6;
  localparam int DC_LINE_WORDS = 4;

  localparam int WORD_BITS = $clog2(DC_LINE_WORDS);
  localparam int OFF_BITS  = WORD_BITS + 2;
  localparam int TAG_BITS  = DC_ADDR_WIDTH - DC_INDEX_BITS - OFF_BITS;
  localparam int LINES     = 1 << DC_INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } dc_state_e;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [DC_ADDR_WIDTH-1:0] a);
    return a[DC_ADDR_WIDTH-1 -: TAG_BITS];
  endfunction

  function automatic logic [DC_INDEX_BITS-1:0] addr_index(input logic [DC_ADDR_WIDTH-1:0] a);
    return a[OFF_BITS +: DC_INDEX_BITS];
  endfunction

  function automatic logic [WORD_BITS-1:0] addr_word(input logic [DC_ADDR_WIDTH-1:0] a);
    return a[2 +: WORD_BITS];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: one combinational read port, one byte-masked word
// write port and a tag-write port that also marks the line valid.
module dcache_array
  import dcache_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DC_INDEX_BITS-1:0] i_rd_index,
  input  logic [WORD_BITS-1:0]     i_rd_word,
  output logic                     o_rd_valid,
  output logic [TAG_BITS-1:0]      o_rd_tag,
  output logic [DC_DATA_WIDTH-1:0] o_rd_data,
  input  logic                     i_wr_en,
  input  logic [DC_INDEX_BITS-1:0] i_wr_index,
  input  logic [WORD_BITS-1:0]     i_wr_word,
  input  logic [DC_DATA_WIDTH-1:0] i_wr_data,
  input  logic [3:0]               i_wr_mask,
  input  logic                     i_tag_we,
  input  logic [DC_INDEX_BITS-1:0] i_tag_index,
  input  logic [TAG_BITS-1:0]      i_tag
);

  logic [LINES-1:0]         r_valid;
  logic [TAG_BITS-1:0]      r_tag  [LINES];
  logic [DC_DATA_WIDTH-1:0] r_data [LINES*DC_LINE_WORDS];

  // Valid bits are the only state that must clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_valid <= '0;
    else if (i_tag_we) r_valid[i_tag_index] <= 1'b1;
  end

  // Tag storage, written when a refill completes.
  always_ff @(posedge clk) begin
    if (i_tag_we) r_tag[i_tag_index] <= i_tag;
  end

  // Byte-masked word write into line data.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wr_mask[b]) r_data[{i_wr_index, i_wr_word}][8*b +: 8] <= i_wr_data[8*b +: 8];
      end
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[{i_rd_index, i_rd_word}];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache with a single
// outstanding transaction. Optional perf counters under DCACHE_PERF_EN.
module data_cache
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
  parameter int DATA_WIDTH = DC_DATA_WIDTH,
  parameter int INDEX_BITS = DC_INDEX_BITS,
  parameter int LINE_WORDS = DC_LINE_WORDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsm_read,
  input  logic [ADDR_WIDTH-1:0] lsm_read_addr,
  output logic                  lsm_read_done,
  output logic [DATA_WIDTH-1:0] lsm_read_data,
  input  logic                  rob_write,
  input  logic [3:0]            rob_mask,
  input  logic [ADDR_WIDTH-1:0] rob_addr,
  input  logic [DATA_WIDTH-1:0] rob_data,
  output logic                  rob_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_mask,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);

  // Field helpers live in the package and are sized from its constants.
  if (ADDR_WIDTH != DC_ADDR_WIDTH || DATA_WIDTH != DC_DATA_WIDTH ||
      INDEX_BITS != DC_INDEX_BITS || LINE_WORDS != DC_LINE_WORDS) begin : g_param_check
    $error("data_cache parameters must match dcache_pkg constants");
  end

  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

  dc_state_e               r_state, w_next_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
  logic [3:0]              r_mask;
  logic                    r_hit, r_is_load;
  logic [WORD_BITS-1:0]    r_cnt;

  logic [ADDR_WIDTH-1:0]   w_rd_addr;
  logic                    w_rd_valid, w_hit;
  logic [TAG_BITS-1:0]     w_rd_tag;
  logic [DATA_WIDTH-1:0]   w_rd_data;
  logic                    w_arr_we, w_tag_we;
  logic [WORD_BITS-1:0]    w_arr_word;
  logic [DATA_WIDTH-1:0]   w_arr_data;
  logic [3:0]              w_arr_mask;
  logic                    w_unused;

  // Lookup uses the incoming request while idle, the latched address otherwise.
  assign w_rd_addr = (r_state != IDLE) ? r_addr : (rob_write ? rob_addr : lsm_read_addr);
  assign w_hit     = w_rd_valid && (w_rd_tag == addr_tag(w_rd_addr));
  assign w_unused  = ^{r_addr[1:0]};

  dcache_array u_array (
    .clk         (clk),
    .rst         (rst),
    .i_rd_index  (addr_index(w_rd_addr)),
    .i_rd_word   (addr_word(w_rd_addr)),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_data   (w_rd_data),
    .i_wr_en     (w_arr_we),
    .i_wr_index  (addr_index(r_addr)),
    .i_wr_word   (w_arr_word),
    .i_wr_data   (w_arr_data),
    .i_wr_mask   (w_arr_mask),
    .i_tag_we    (w_tag_we),
    .i_tag_index (addr_index(r_addr)),
    .i_tag       (addr_tag(r_addr))
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state, memory port, response and array write control.
  always_comb begin
    w_next_state  = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_mask      = '0;
    lsm_read_done = 1'b0;
    lsm_read_data = '0;
    rob_valid     = 1'b0;
    w_arr_we      = 1'b0;
    w_arr_word    = '0;
    w_arr_data    = '0;
    w_arr_mask    = '0;
    w_tag_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (rob_write)     w_next_state = WRITE;
        else if (lsm_read) w_next_state = w_hit ? RESP : REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[ADDR_WIDTH-1:OFF_BITS], r_cnt, 2'b00};
        if (mem_ack) begin
          w_arr_we   = 1'b1;
          w_arr_word = r_cnt;
          w_arr_data = mem_rdata;
          w_arr_mask = 4'hF;
          if (r_cnt == LAST_WORD) begin
            w_tag_we     = 1'b1;
            w_next_state = RESP;
          end
        end
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata = r_wdata;
        mem_mask  = r_mask;
        if (mem_ack) begin
          w_arr_we     = r_hit;
          w_arr_word   = addr_word(r_addr);
          w_arr_data   = r_wdata;
          w_arr_mask   = r_mask;
          w_next_state = RESP;
        end
      end
      RESP: begin
        lsm_read_done = r_is_load;
        lsm_read_data = r_is_load ? r_rdata : '0;
        rob_valid     = !r_is_load;
        w_next_state  = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Request latching, refill word counter and load result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_hit     <= 1'b0;
      r_is_load <= 1'b0;
      r_cnt     <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (rob_write) begin
            r_addr    <= rob_addr;
            r_wdata   <= rob_data;
            r_mask    <= rob_mask;
            r_hit     <= w_hit;
            r_is_load <= 1'b0;
          end else if (lsm_read) begin
            r_addr    <= lsm_read_addr;
            r_is_load <= 1'b1;
            r_cnt     <= '0;
            if (w_hit) r_rdata <= w_rd_data;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == addr_word(r_addr)) r_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_PERF_EN
  logic [31:0] r_hit_count, r_miss_count;

  // Count each accepted load once, as a hit or a miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == IDLE && !rob_write && lsm_read) begin
      if (w_hit) r_hit_count  <= r_hit_count + 32'd1;
      else       r_miss_count <= r_miss_count + 32'd1;
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Responder end of the core's data-memory interface. Serves LoadStore read requests and ROB commit-time store requests.
- Direct-mapped, write-through, no-write-allocate cache between the core and a word-wide backing-memory port with request/acknowledge.
- Miss refill fetches a full line one word at a time. Exactly one outstanding transaction at any time.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; fixed to 4 bytes
- INDEX_BITS, 6, log2 of number of lines (64 lines)
- LINE_WORDS, 4, words per line; power of two ≥2
- Derived: OFF_BITS = log2(LINE_WORDS)+2; TAG_BITS = ADDR_WIDTH-INDEX_BITS-OFF_BITS

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- lsm_read  in  1  load request; held with address until lsm_read_done
- lsm_read_addr  in  ADDR_WIDTH  load byte address; bits[1:0] ignored
- lsm_read_done  out  1  one-cycle pulse: load complete
- lsm_read_data  out  DATA_WIDTH  load word; valid while lsm_read_done=1
- rob_write  in  1  store request; held with addr/data/mask until rob_valid
- rob_mask  in  4  byte enables; bit i covers data[8i+7:8i]
- rob_addr  in  ADDR_WIDTH  store byte address; bits[1:0] ignored
- rob_data  in  DATA_WIDTH  store word
- rob_valid  out  1  one-cycle pulse: store committed to memory
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_WIDTH  word-aligned memory address
- mem_wdata  out  DATA_WIDTH  write data
- mem_mask  out  4  write byte enables
- mem_ack  in  1  one-cycle completion; mem_rdata valid with it
- mem_rdata  in  DATA_WIDTH  read data
- hit_count  out  32  perf counter (see Optional Feature)
- miss_count  out  32  perf counter

Behaviour:
- Reset: all valid bits cleared; state IDLE. All outputs 0, applied immediately on rst assertion (async), including mid-transaction: mem_req drops, partial refill is discarded, line stays invalid.
- States: IDLE, REFILL, WRITE, RESP.
- IDLE:
  - rob_write has priority over lsm_read when both are high.
  - Store: latch addr/data/mask and hit flag -> WRITE.
  - Load hit (valid & tag match): latch the word -> RESP. lsm_read_done is asserted the next cycle, i.e. 1-cycle hit latency.
  - Load miss -> REFILL with word counter = 0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {tag,index,counter,2'b00}. Words are fetched in order 0..LINE_WORDS-1.
  - On each mem_ack, write mem_rdata into the line word and increment the counter.
  - After the last ack: set tag and valid, latch the requested word -> RESP.
- WRITE:
  - mem_req=1, mem_we=1, mem_mask=rob_mask, word-aligned mem_addr, mem_wdata=rob_data.
  - On mem_ack: if the latched hit flag is set, merge the masked bytes into the cached word. A miss does not allocate. -> RESP.
  - mask 0000 still issues the memory write and completes normally.
- RESP:
  - Pulse lsm_read_done (with lsm_read_data) or rob_valid for exactly one cycle.
  - Inputs are ignored this cycle so the requester can drop its request. Then -> IDLE.
- A load issued after a completed store to the same word returns the merged data, from cache on a hit or from memory on a miss.
- mem_req, mem_addr, mem_we, mem_wdata and mem_mask are stable while waiting for mem_ack.
- Outputs not named above are 0 outside the states that drive them.

Optional Feature:
- Macro DCACHE_PERF_EN.
- Defined: hit_count increments once per accepted load hit; miss_count increments once per accepted load miss. Both reset to 0 and wrap at 2^32. Stores are not counted.
- Undefined: no counter logic; both ports tied to 0.

Decomposition:
- Package dcache_pkg holds:
  - state enum (IDLE, REFILL, WRITE, RESP)
  - derived widths OFF_BITS, TAG_BITS
  - address field-extract helper functions (tag, index, word offset)
- Sub-module dcache_array: tag/valid/data storage with one read port and one word-write-with-byte-mask port, plus a tag-write/valid-set port. Valid bits clear on rst.

Test Plan:
- Cold load 0x100, memory words 0x11,0x22,0x33,0x44 at 0x100..0x10C -> mem reads in order 0x100,0x104,0x108,0x10C; lsm_read_done with data 0x11; miss_count=1.
- Load 0x108 after fill -> no mem_req; done exactly 1 cycle after acceptance with 0x33; hit_count=1.
- Store 0xAAAABBBB, mask 0011 to 0x104 (hit) -> one mem write with mask 0011, rob_valid pulse; then load 0x104 returns 0x0000BBBB (original 0x22 upper bytes 0x0000) with no mem_req.
- Store to uncached 0x900 then load 0x900 -> store does not allocate; load misses and refills line 0x900..0x90C.
- lsm_read and rob_write asserted together -> store completes (rob_valid) before any load activity; load then completes.
- Load 0x500 (same index as 0x100, different tag) evicts line -> subsequent load 0x100 misses again. Assert rst after 2 refill acks -> mem_req=0 immediately; after reset, load 0x500 misses.
